// File: rtl/traffic_light_n_phase.sv
// N-phase round-robin intersection controller with latched pedestrian requests,
// minimum-green early termination and emergency all-red preemption.
module traffic_light_n_phase #(
    parameter int NUM_PHASES    = 4,
    parameter int GREEN_CYC     = 20,
    parameter int MIN_GREEN_CYC = 8,
    parameter int YELLOW_CYC    = 4,
    parameter int ALLRED_CYC    = 2,
    parameter int WALK_CYC      = 4,
    parameter int CNT_W         = 8,
    localparam int PH_W         = $clog2(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PHASES-1:0] ped_req,
    input  logic                  emg,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic [NUM_PHASES-1:0] walk,
    output logic [PH_W-1:0]       phase,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_GREEN    = 2'd0,
        ST_YELLOW   = 2'd1,
        ST_ALLRED   = 2'd2,
        ST_EMG_HOLD = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LEN    = CNT_W'(WALK_CYC);
    localparam logic [PH_W-1:0]  LAST_PHASE  = PH_W'(NUM_PHASES - 1);

    state_e                  state_q, state_d;
    logic [PH_W-1:0]         cur_q, cur_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_PHASES-1:0]   ped_pend_q, ped_pend_d;
    logic                    walk_en_q, walk_en_d;

    logic [PH_W-1:0]         nxt_phase;
    logic [NUM_PHASES-1:0]   cur_mask;
    logic                    foreign_req;

    assign nxt_phase   = (cur_q == LAST_PHASE) ? '0 : cur_q + PH_W'(1);
    assign cur_mask    = {{(NUM_PHASES-1){1'b0}}, 1'b1} << cur_q;
    assign foreign_req = |(ped_pend_q & ~cur_mask);

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q + CNT_W'(1);
        walk_en_d = walk_en_q;

        // A request for the phase whose crossing is already open is dropped.
        for (int i = 0; i < NUM_PHASES; i++) begin
            ped_pend_d[i] = ped_pend_q[i] |
                            (ped_req[i] & ~(state_q == ST_GREEN && cur_q == PH_W'(i)));
        end

        case (state_q)
            ST_GREEN: begin
                if (emg || cnt_q == GREEN_LAST || (cnt_q >= MIN_LAST && foreign_req)) begin
                    state_d = ST_YELLOW;
                    cnt_d   = '0;
                end
            end
            ST_YELLOW: begin
                if (cnt_q == YELLOW_LAST) begin
                    state_d = ST_ALLRED;
                    cnt_d   = '0;
                end
            end
            ST_ALLRED: begin
                if (cnt_q == ALLRED_LAST) begin
                    cnt_d = '0;
                    if (emg) begin
                        state_d = ST_EMG_HOLD;
                    end else begin
                        state_d               = ST_GREEN;
                        cur_d                 = nxt_phase;
                        walk_en_d             = ped_pend_q[nxt_phase];
                        ped_pend_d[nxt_phase] = 1'b0;
                    end
                end
            end
            default: begin
                cnt_d = '0;
                if (!emg) state_d = ST_ALLRED;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_ALLRED;
            cur_q      <= LAST_PHASE;
            cnt_q      <= '0;
            ped_pend_q <= '0;
            walk_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
            walk_en_q  <= walk_en_d;
        end
    end

    // Lamps decode from registers only, so async reset reaches them at once.
    assign green  = (state_q == ST_GREEN)  ? cur_mask : '0;
    assign yellow = (state_q == ST_YELLOW) ? cur_mask : '0;
    assign red    = ~(green | yellow);
    assign walk   = (state_q == ST_GREEN && walk_en_q && cnt_q < WALK_LEN) ? cur_mask : '0;
    assign phase  = cur_q;
    assign state  = state_q;

endmodule

// File: tb/tb_traffic_light_n_phase.sv
// Directed bench for traffic_light_n_phase: N=4, GREEN=10, MIN=4, YELLOW=3, ALLRED=2, WALK=3.
module tb_traffic_light_n_phase;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ped_req = '0;
    logic       emg = 1'b0;
    logic [3:0] green, yellow, red, walk;
    logic [1:0] phase, state;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    traffic_light_n_phase #(
        .NUM_PHASES(4), .GREEN_CYC(10), .MIN_GREEN_CYC(4), .YELLOW_CYC(3),
        .ALLRED_CYC(2), .WALK_CYC(3), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .ped_req(ped_req), .emg(emg),
        .green(green), .yellow(yellow), .red(red), .walk(walk),
        .phase(phase), .state(state)
    );

    always #5 clk = ~clk;

    // Expected vector {state, phase, green, yellow, red, walk}; red is every non-lit phase.
    function automatic logic [19:0] pk(logic [1:0] st, logic [1:0] ph,
                                       logic [3:0] g, logic [3:0] y, logic [3:0] w);
        return {st, ph, g, y, ~(g | y), w};
    endfunction

    function automatic logic [19:0] obs();
        return {state, phase, green, yellow, red, walk};
    endfunction

    // Advance to just after edge k (edges counted from reset release).
    task automatic goto_edge(input int k);
        if (edge_n < k) begin
            while (edge_n < k) begin
                @(posedge clk);
                edge_n++;
            end
            #1;
        end
    endtask

    task automatic do_reset();
        ped_req = '0;
        emg     = 1'b0;
        rst     = 1'b1;
        #1 rst  = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        ped_req = '0;
        emg     = 1'b0;
        rst     = 1'b1;
        #1 rst  = 1'b0;
        #1;
        checks++;
        if (obs() !== pk(2'd2, 2'd3, 4'b0, 4'b0, 4'b0)) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", obs(), pk(2'd2, 2'd3, 4'b0, 4'b0, 4'b0));
        end
        @(negedge clk);
        rst    = 1'b1;
        edge_n = 0;
        goto_edge(1);
        checks++;
        if (obs() !== pk(2'd2, 2'd3, 4'b0, 4'b0, 4'b0)) begin
            failures++;
            $display("FAIL reset_edge1 got=%h exp=%h", obs(), pk(2'd2, 2'd3, 4'b0, 4'b0, 4'b0));
        end
    endtask

    task automatic test_free_run();
        int          ed [11];
        logic [19:0] ex [11];
        ed = '{2, 11, 12, 14, 15, 16, 17, 32, 61, 62, 71};
        ex = '{pk(0, 0, 4'b0001, 0, 0), pk(0, 0, 4'b0001, 0, 0), pk(1, 0, 0, 4'b0001, 0),
               pk(1, 0, 0, 4'b0001, 0), pk(2, 0, 0, 0, 0),       pk(2, 0, 0, 0, 0),
               pk(0, 1, 4'b0010, 0, 0), pk(0, 2, 4'b0100, 0, 0), pk(2, 3, 0, 0, 0),
               pk(0, 0, 4'b0001, 0, 0), pk(0, 0, 4'b0001, 0, 0)};
        do_reset();
        for (int k = 0; k < 11; k++) begin
            goto_edge(ed[k]);
            checks++;
            if (obs() !== ex[k]) begin
                failures++;
                $display("FAIL free_run edge=%0d got=%h exp=%h", edge_n, obs(), ex[k]);
            end
        end
    endtask

    task automatic test_ped_early();
        int          ed [13];
        logic [19:0] ex [13];
        ed = '{4, 5, 6, 9, 11, 14, 15, 20, 22, 23, 29, 30, 80};
        ex = '{pk(0, 0, 4'b0001, 0, 0), pk(0, 0, 4'b0001, 0, 0), pk(1, 0, 0, 4'b0001, 0),
               pk(2, 0, 0, 0, 0),       pk(0, 1, 4'b0010, 0, 0), pk(0, 1, 4'b0010, 0, 0),
               pk(1, 1, 0, 4'b0010, 0), pk(0, 2, 4'b0100, 0, 4'b0100),
               pk(0, 2, 4'b0100, 0, 4'b0100), pk(0, 2, 4'b0100, 0, 0),
               pk(0, 2, 4'b0100, 0, 0), pk(1, 2, 0, 4'b0100, 0), pk(0, 2, 4'b0100, 0, 0)};
        do_reset();
        for (int k = 0; k < 13; k++) begin
            goto_edge(ed[k]);
            checks++;
            if (obs() !== ex[k]) begin
                failures++;
                $display("FAIL ped_early edge=%0d got=%h exp=%h", edge_n, obs(), ex[k]);
            end
            if (ed[k] == 4) ped_req = 4'b0100;
            if (ed[k] == 5) ped_req = 4'b0000;
        end
    endtask

    task automatic test_ped_own();
        int          ed [7];
        logic [19:0] ex [7];
        ed = '{2, 5, 11, 12, 26, 27, 62};
        ex = '{pk(0, 0, 4'b0001, 0, 0), pk(0, 0, 4'b0001, 0, 0), pk(0, 0, 4'b0001, 0, 0),
               pk(1, 0, 0, 4'b0001, 0), pk(0, 1, 4'b0010, 0, 0), pk(1, 1, 0, 4'b0010, 0),
               pk(0, 0, 4'b0001, 0, 0)};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            goto_edge(ed[k]);
            checks++;
            if (obs() !== ex[k]) begin
                failures++;
                $display("FAIL ped_own edge=%0d got=%h exp=%h", edge_n, obs(), ex[k]);
            end
            if (ed[k] == 2)  ped_req = 4'b0001;
            if (ed[k] == 11) ped_req = 4'b0000;
        end
    endtask

    task automatic test_emg();
        int          ed [10];
        logic [19:0] ex [10];
        ed = '{4, 5, 7, 8, 9, 10, 30, 31, 32, 33};
        ex = '{pk(0, 0, 4'b0001, 0, 0), pk(1, 0, 0, 4'b0001, 0), pk(1, 0, 0, 4'b0001, 0),
               pk(2, 0, 0, 0, 0), pk(2, 0, 0, 0, 0), pk(3, 0, 0, 0, 0), pk(3, 0, 0, 0, 0),
               pk(2, 0, 0, 0, 0), pk(2, 0, 0, 0, 0), pk(0, 1, 4'b0010, 0, 0)};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            goto_edge(ed[k]);
            checks++;
            if (obs() !== ex[k]) begin
                failures++;
                $display("FAIL emg edge=%0d got=%h exp=%h", edge_n, obs(), ex[k]);
            end
            if (ed[k] == 4)  emg = 1'b1;
            if (ed[k] == 30) emg = 1'b0;
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        goto_edge(13);
        checks++;
        if (obs() !== pk(1, 0, 0, 4'b0001, 0)) begin
            failures++;
            $display("FAIL rst_mid_pre got=%h exp=%h", obs(), pk(1, 0, 0, 4'b0001, 0));
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs() !== pk(2, 3, 0, 0, 0)) begin
            failures++;
            $display("FAIL rst_mid_async got=%h exp=%h", obs(), pk(2, 3, 0, 0, 0));
        end
        @(negedge clk);
        rst    = 1'b1;
        edge_n = 0;
        goto_edge(1);
        checks++;
        if (obs() !== pk(2, 3, 0, 0, 0)) begin
            failures++;
            $display("FAIL rst_mid_edge1 got=%h exp=%h", obs(), pk(2, 3, 0, 0, 0));
        end
        goto_edge(2);
        checks++;
        if (obs() !== pk(0, 0, 4'b0001, 0, 0)) begin
            failures++;
            $display("FAIL rst_mid_edge2 got=%h exp=%h", obs(), pk(0, 0, 4'b0001, 0, 0));
        end
    endtask

    task automatic test_emg_ped();
        int          ed [11];
        logic [19:0] ex [11];
        ed = '{4, 5, 10, 12, 13, 15, 19, 28, 33, 36, 43};
        ex = '{pk(0, 0, 4'b0001, 0, 0), pk(1, 0, 0, 4'b0001, 0), pk(3, 0, 0, 0, 0),
               pk(3, 0, 0, 0, 0), pk(2, 0, 0, 0, 0), pk(0, 1, 4'b0010, 0, 0),
               pk(1, 1, 0, 4'b0010, 0), pk(1, 2, 0, 4'b0100, 0),
               pk(0, 3, 4'b1000, 0, 4'b1000), pk(0, 3, 4'b1000, 0, 0), pk(1, 3, 0, 4'b1000, 0)};
        do_reset();
        for (int k = 0; k < 11; k++) begin
            goto_edge(ed[k]);
            checks++;
            if (obs() !== ex[k]) begin
                failures++;
                $display("FAIL emg_ped edge=%0d got=%h exp=%h", edge_n, obs(), ex[k]);
            end
            if (ed[k] == 4) begin
                emg     = 1'b1;
                ped_req = 4'b1000;
            end
            if (ed[k] == 5)  ped_req = 4'b0000;
            if (ed[k] == 12) emg = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ped_early();
        test_ped_own();
        test_emg();
        test_rst_mid();
        test_emg_ped();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_light_n_phase.md
# traffic_light_n_phase

Parametrised N-phase intersection controller, successor to the fixed two-direction 4-lane controller. Serves NUM_PHASES signal groups round-robin through green, yellow and all-red intervals with per-phase timing. It adds three things the fixed controller does not have:
- latched per-phase pedestrian requests with walk indication;
- minimum-green early termination;
- an emergency all-red preemption mode.

It sits directly behind the lamp drivers and is clocked from the system tick clock.

## Interface
- NUM_PHASES, 4, number of signal groups (≥2)
- GREEN_CYC, 20, maximum green duration in clk cycles
- MIN_GREEN_CYC, 8, minimum green before early termination (≤ GREEN_CYC)
- YELLOW_CYC, 4, yellow duration
- ALLRED_CYC, 2, all-red clearance duration
- WALK_CYC, 4, walk indication duration (≤ MIN_GREEN_CYC)
- CNT_W, 8, timer width; every *_CYC must be ≤ 2^CNT_W − 1 and ≥ 1
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ped_req  in  NUM_PHASES  pedestrian request per phase, level-sampled each cycle
- emg  in  1  emergency preemption request, level
- green  out  NUM_PHASES  one-hot green lamps (all zero outside GREEN)
- yellow  out  NUM_PHASES  one-hot yellow lamps
- red  out  NUM_PHASES  red lamps (every phase not green/yellow)
- walk  out  NUM_PHASES  pedestrian walk per phase
- phase  out  clog2(NUM_PHASES)  index of current/last served phase
- state  out  2  0=GREEN, 1=YELLOW, 2=ALLRED, 3=EMG_HOLD

## Operation
- Registers: state, cur (phase), cnt (CNT_W), ped_pend[N], walk_en.
- All outputs are decoded from registers only (Moore); there is no combinational input→output path.
- Reset (rst=0, async):
  - state=ALLRED, cur=NUM_PHASES−1, cnt=0, ped_pend=0, walk_en=0.
  - Outputs: red=all ones, green=yellow=walk=0, phase=NUM_PHASES−1, state=2.
- cnt increments each cycle in a state and clears to 0 on every state transition.
- GREEN (cur):
  - green[cur]=1.
  - Exits to YELLOW when cnt==GREEN_CYC−1, or when cnt≥MIN_GREEN_CYC−1 and ped_pend has any bit set other than cur.
  - Exits to YELLOW on the cycle after emg is sampled high, regardless of the minimum-green rule.
- YELLOW: yellow[cur]=1. Always runs the full YELLOW_CYC (emg does not shorten it), then goes to ALLRED.
- ALLRED: all red. At cnt==ALLRED_CYC−1:
  - emg=1 → EMG_HOLD.
  - otherwise → GREEN with cur=(cur+1) mod NUM_PHASES (wraps N−1→0).
- EMG_HOLD: all red, cnt held at 0. On emg=0 → ALLRED (full clearance), then the next phase in round-robin order. No phase is skipped or repeated.
- Phases are served strictly in round-robin order. A request only shortens the current green; it never reorders phases.
- Pedestrian latch:
  - ped_pend[i] is set when ped_req[i]=1, except when state==GREEN and cur==i (the request is dropped because the crossing is already open).
  - Latching continues in all states, including EMG_HOLD.
- Entering GREEN for phase i:
  - walk_en is loaded with ped_pend[i].
  - ped_pend[i] is cleared on the same edge. A simultaneous ped_req[i] on that edge is not latched.
- walk[i]=1 while state==GREEN, cur==i, walk_en=1 and cnt<WALK_CYC. Otherwise walk=0.

## Timing
- Edge k means the k-th rising clk edge after rst deasserts. Outputs change only on edges.
- First green: phase 0 after edge ALLRED_CYC.
- Undisturbed per-phase period is GREEN_CYC+YELLOW_CYC+ALLRED_CYC edges.
- Early termination: yellow appears one edge after cnt reaches MIN_GREEN_CYC−1 with a foreign request pending. If the request is latched later, yellow appears one edge after the latch edge.
- emg response: yellow appears ≤1 edge after emg is sampled high in GREEN. All-red is reached within YELLOW_CYC+1 edges.
- Async reset mid-operation returns all outputs to their reset values immediately, without waiting for clk.

## Test plan
Common parameters: N=4, GREEN=10, MIN=4, YELLOW=3, ALLRED=2, WALK=3.
- Reset/free-run, no inputs → phase0 green at edges 2..11, yellow 12..14, all-red 15..16; phase1 green at 17; phase0 green again at edge 62 (wrap 3→0).
- ped_req[2] pulsed for 1 cycle at edge 5:
  - phase0 yellow after edge 6, phase1 green after 11, phase1 yellow after 15;
  - phase2 green after 20 with walk[2]=1 for edges 20..22, ped_pend[2] cleared;
  - phase2 runs the full 10-cycle green.
- ped_req[0] held high while phase0 is green → not latched; phase0 green runs the full 10 cycles; walk stays 0.
- emg raised at edge 4 and released at edge 30:
  - yellow after edge 5, all-red after 8, EMG_HOLD after 10;
  - after release: all-red for 2 edges, then phase1 green.
- rst asserted mid-yellow → outputs immediately red=1111, green=yellow=walk=0, state=2; after release, phase0 green at edge 2.
- emg and ped_req[3] high together during GREEN → emergency wins; ped_pend[3] stays latched; walk[3] asserts when phase3 is next served.
